// File: rtl/level_step_arbiter_pkg.sv
// Shared types and constants for the level step arbiter.
package level_step_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } req_t;

    localparam logic [1:0] LEVEL_MAX = 2'd3;

    // One-deep request slot: keeps an existing request, otherwise takes a
    // single up or down edge; an up and down edge together cancel out.
    function automatic req_t capture_req(input req_t cur, input logic up, input logic dn);
        if (cur != NONE) begin
            return cur;
        end else if (up && !dn) begin
            return UP;
        end else if (dn && !up) begin
            return DN;
        end else begin
            return NONE;
        end
    endfunction

endpackage

// File: rtl/level_step_arbiter_rise_edge.sv
// Rising-edge detector for a clk-synchronous button level.
// The delay register resets to 1 so a button held through reset gives no edge.
module rise_edge
    import level_step_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic dly;

    // Previous-cycle copy of the button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly <= 1'b1;
        end else begin
            dly <= sig;
        end
    end

    assign rise = sig & ~dly;

endmodule

// File: rtl/level_step_arbiter.sv
// Two-requester arbiter stepping a shared 0..3 level up or down.
// Each grant is followed by a lockout of HOLD_CYCLES cycles; requests that
// arrive meanwhile are queued one-deep per requester and served round-robin.
module level_step_arbiter
    import level_step_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_up,
    input  logic       a_dn,
    input  logic       b_up,
    input  logic       b_dn,
    output logic [1:0] level,
    output logic       ack_a,
    output logic       ack_b,
    output logic       sat,
    output logic       busy
);

    // Counter counts down from HOLD_CYCLES-1 to 0, giving HOLD_CYCLES cycles in HOLD.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    logic       a_up_rise, a_dn_rise, b_up_rise, b_dn_rise;

    state_t     state, state_next;
    req_t       pend_a, pend_a_next;
    req_t       pend_b, pend_b_next;
    logic       prio_b, prio_b_next;
    logic [3:0] hold_cnt, hold_cnt_next;
    logic [1:0] level_next;
    logic       ack_a_next, ack_b_next, sat_next;
    logic       grant_a, grant_b;
    req_t       grant_req;
    logic [2:0] stepped;

    // Returns {clipped, new_level}; a clipped step keeps the level unchanged.
    function automatic logic [2:0] sat_step(input logic [1:0] lvl, input req_t req);
        case (req)
            UP: begin
                if (lvl == LEVEL_MAX) return {1'b1, lvl};
                else                  return {1'b0, lvl + 2'd1};
            end
            DN: begin
                if (lvl == 2'd0) return {1'b1, lvl};
                else             return {1'b0, lvl - 2'd1};
            end
            default: return {1'b0, lvl};
        endcase
    endfunction

    rise_edge u_a_up (.clk(clk), .rst_n(rst_n), .sig(a_up), .rise(a_up_rise));
    rise_edge u_a_dn (.clk(clk), .rst_n(rst_n), .sig(a_dn), .rise(a_dn_rise));
    rise_edge u_b_up (.clk(clk), .rst_n(rst_n), .sig(b_up), .rise(b_up_rise));
    rise_edge u_b_dn (.clk(clk), .rst_n(rst_n), .sig(b_dn), .rise(b_dn_rise));

    // Arbitration, level stepping, hold timing and pending-slot update.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        prio_b_next   = prio_b;
        level_next    = level;
        ack_a_next    = 1'b0;
        ack_b_next    = 1'b0;
        sat_next      = 1'b0;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        grant_req     = NONE;
        stepped       = {1'b0, level};

        case (state)
            IDLE: begin
                if (pend_a != NONE && (pend_b == NONE || !prio_b)) begin
                    grant_a = 1'b1;
                end else if (pend_b != NONE) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    grant_req     = grant_a ? pend_a : pend_b;
                    stepped       = sat_step(level, grant_req);
                    level_next    = stepped[1:0];
                    sat_next      = stepped[2];
                    ack_a_next    = grant_a;
                    ack_b_next    = grant_b;
                    // The requester just served loses priority to the other.
                    prio_b_next   = grant_a;
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A slot being granted this cycle is still occupied, so a new edge
        // in the same cycle is dropped rather than queued.
        pend_a_next = grant_a ? NONE : capture_req(pend_a, a_up_rise, a_dn_rise);
        pend_b_next = grant_b ? NONE : capture_req(pend_b, b_up_rise, b_dn_rise);
    end

    // State, pending slots, pointer, level and grant pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            pend_a   <= NONE;
            pend_b   <= NONE;
            prio_b   <= 1'b0;
            level    <= 2'd0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            sat      <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            pend_a   <= pend_a_next;
            pend_b   <= pend_b_next;
            prio_b   <= prio_b_next;
            level    <= level_next;
            ack_a    <= ack_a_next;
            ack_b    <= ack_b_next;
            sat      <= sat_next;
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_level_step_arbiter.sv
// Directed, table-driven bench for level_step_arbiter (HOLD_CYCLES = 4).
module tb_level_step_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_up = 1'b0, a_dn = 1'b0, b_up = 1'b0, b_dn = 1'b0;
    logic [1:0] level;
    logic       ack_a, ack_b, sat, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // btn = {a_up, a_dn, b_up, b_dn}; flags = {ack_a, ack_b, sat, busy}
    typedef struct {
        logic [3:0] btn;
        logic [1:0] lvl;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[$];

    level_step_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_up  (a_up),
        .a_dn  (a_dn),
        .b_up  (b_up),
        .b_dn  (b_dn),
        .level (level),
        .ack_a (ack_a),
        .ack_b (ack_b),
        .sat   (sat),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int idx, input logic [1:0] lvl, input logic [3:0] flags);
        check({name, ".level"}, idx, level, lvl);
        check({name, ".ack_a"}, idx, {1'b0, ack_a}, {1'b0, flags[3]});
        check({name, ".ack_b"}, idx, {1'b0, ack_b}, {1'b0, flags[2]});
        check({name, ".sat"},   idx, {1'b0, sat},   {1'b0, flags[1]});
        check({name, ".busy"},  idx, {1'b0, busy},  {1'b0, flags[0]});
    endtask

    task automatic add(input logic [3:0] btn, input logic [1:0] lvl, input logic [3:0] flags, input int reps);
        vec_t v;
        v.btn = btn;
        v.lvl = lvl;
        v.flags = flags;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_all("reset", 0, 2'd0, 4'b0000);
        rst_n = 1'b1;

        // idle cycle so the delay registers leave their reset value of 1
        add(4'b0000, 2'd0, 4'b0000, 1);
        // a_up pulse: pending, then level 0->1 with ack_a, busy for 4 cycles
        add(4'b1000, 2'd0, 4'b0000, 1);
        add(4'b0000, 2'd1, 4'b1001, 1);
        add(4'b0000, 2'd1, 4'b0001, 3);
        add(4'b0000, 2'd1, 4'b0000, 1);
        // b_dn pulse: level 1->0, pointer back to A
        add(4'b0001, 2'd1, 4'b0000, 1);
        add(4'b0000, 2'd0, 4'b0101, 1);
        add(4'b0000, 2'd0, 4'b0001, 3);
        add(4'b0000, 2'd0, 4'b0000, 1);
        // a_up and b_up together: A first, B HOLD+1 edges later
        add(4'b1010, 2'd0, 4'b0000, 1);
        add(4'b0000, 2'd1, 4'b1001, 1);
        add(4'b0000, 2'd1, 4'b0001, 3);
        add(4'b0000, 2'd1, 4'b0000, 1);
        add(4'b0000, 2'd2, 4'b0101, 1);
        add(4'b0000, 2'd2, 4'b0001, 3);
        add(4'b0000, 2'd2, 4'b0000, 1);
        // a_up to level 3
        add(4'b1000, 2'd2, 4'b0000, 1);
        add(4'b0000, 2'd3, 4'b1001, 1);
        add(4'b0000, 2'd3, 4'b0001, 3);
        add(4'b0000, 2'd3, 4'b0000, 1);
        // b_up at level 3: clipped, ack_b with sat, still holds
        add(4'b0010, 2'd3, 4'b0000, 1);
        add(4'b0000, 2'd3, 4'b0111, 1);
        add(4'b0000, 2'd3, 4'b0001, 3);
        add(4'b0000, 2'd3, 4'b0000, 1);
        // a_up and a_dn in the same cycle: discarded
        add(4'b1100, 2'd3, 4'b0000, 1);
        add(4'b0000, 2'd3, 4'b0000, 2);
        // b_dn grant, then two a_up pulses during HOLD: one further grant only
        add(4'b0001, 2'd3, 4'b0000, 1);
        add(4'b0000, 2'd2, 4'b0101, 1);
        add(4'b1000, 2'd2, 4'b0001, 1);
        add(4'b0000, 2'd2, 4'b0001, 1);
        add(4'b1000, 2'd2, 4'b0001, 1);
        add(4'b0000, 2'd2, 4'b0000, 1);
        add(4'b0000, 2'd3, 4'b1001, 1);
        add(4'b0000, 2'd3, 4'b0001, 3);
        add(4'b0000, 2'd3, 4'b0000, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            {a_up, a_dn, b_up, b_dn} = vecs[i].btn;
            tick();
            check_all("vec", i, vecs[i].lvl, vecs[i].flags);
        end

        // a_up held high through reset release: no edge, no grant
        a_up  = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        check_all("held_rst", 0, 2'd0, 4'b0000);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_all("held_rst", i, 2'd0, 4'b0000);
        end
        a_up = 1'b0;
        tick();
        check_all("held_rst", 5, 2'd0, 4'b0000);

        // a_dn at level 0: clipped, ack_a with sat
        a_dn = 1'b1;
        tick();
        check_all("dn_at_0", 0, 2'd0, 4'b0000);
        a_dn = 1'b0;
        tick();
        check_all("dn_at_0", 1, 2'd0, 4'b1011);
        for (int i = 2; i <= HOLD; i++) begin
            tick();
            check_all("dn_at_0", i, 2'd0, 4'b0001);
        end
        tick();
        check_all("dn_at_0", HOLD + 1, 2'd0, 4'b0000);

        // reset mid-HOLD with B pending: everything discarded
        a_up = 1'b1;
        tick();
        check_all("rst_hold", 0, 2'd0, 4'b0000);
        a_up = 1'b0;
        tick();
        check_all("rst_hold", 1, 2'd1, 4'b1001);
        b_up = 1'b1;
        tick();
        check_all("rst_hold", 2, 2'd1, 4'b0001);
        b_up  = 1'b0;
        rst_n = 1'b0;
        tick();
        check_all("rst_hold", 3, 2'd0, 4'b0000);
        rst_n = 1'b1;
        for (int i = 4; i < 12; i++) begin
            tick();
            check_all("rst_hold", i, 2'd0, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/level_step_arbiter.md
LEVEL_STEP_ARBITER -- requirements
Module: level_step_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, lockout length in clk cycles after each grant; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a_up  input  1  requester A increment button, level, clk-synchronous.
REQ-005 a_dn  input  1  requester A decrement button.
REQ-006 b_up  input  1  requester B increment button.
REQ-007 b_dn  input  1  requester B decrement button.
REQ-008 level  output  2  shared level register, 0..3, registered.
REQ-009 ack_a  output  1  one-cycle pulse: A's request granted.
REQ-010 ack_b  output  1  one-cycle pulse: B's request granted.
REQ-011 sat  output  1  one-cycle pulse: granted step clipped at 0 or 3.
REQ-012 busy  output  1  high while in HOLD.

Function
REQ-013 Each button SHALL be sampled into a delay register every cycle; edge = button & ~delayed.
REQ-014 Each requester SHALL have a one-deep pending request {none, up, down}, set at the clk edge where its edge term is high.
REQ-015 Simultaneous up and down edges from one requester in the same cycle SHALL be discarded (no pending set).
REQ-016 Edges arriving while that requester already has a pending request SHALL be ignored.
REQ-017 Pending capture SHALL occur in every state, including HOLD.
REQ-018 FSM states: IDLE, HOLD; IDLE -> HOLD on a grant, HOLD -> IDLE when the hold counter expires.
REQ-019 In IDLE with at least one pending request, exactly one SHALL be granted at the next edge.
REQ-020 Arbitration: single pending wins; if both pending, the requester not granted most recently wins (round-robin pointer; A favoured after reset).
REQ-021 On grant: up -> level+1, down -> level-1, saturating at 3 and 0.
REQ-022 On grant: matching ack pulses high one cycle, pending cleared, pointer updated.
REQ-023 A clipped step SHALL leave level unchanged, assert sat with the ack, and still enter HOLD.
REQ-024 Latency: edge term high in cycle before edge k -> pending at k -> level/ack update at k+1 (IDLE, winning).
REQ-025 HOLD SHALL last exactly HOLD_CYCLES cycles; next grant no earlier than HOLD_CYCLES+1 edges after the previous one.
REQ-026 busy SHALL be high exactly during HOLD cycles.
REQ-027 ack_a, ack_b, sat SHALL be 0 except in the single cycle after a grant edge.

Reset
REQ-028 rst_n low at an edge: level=0, ack_a=ack_b=sat=busy=0, state IDLE, pendings cleared, pointer=A, hold counter 0.
REQ-029 Button delay registers SHALL reset to 1, so buttons held through reset produce no edge.
REQ-030 Reset asserted mid-HOLD or with pending requests SHALL discard them; no ack after release.

Structure
REQ-031 Shared package SHALL hold the state enum {IDLE, HOLD}, the request enum {NONE, UP, DN}, and LEVEL_MAX=3.
REQ-032 One sub-module, rise_edge (delay register plus edge term, reset value 1), SHALL be instantiated four times.
REQ-033 Arbitration, saturation and hold counter SHALL stay in the top module.

Verification
REQ-034 Reset release, a_up pulsed 1 cycle -> level 0->1 two edges later, ack_a one cycle, busy 4 cycles.
REQ-035 a_up and b_up edges same cycle at level 0 -> A granted (level 1), B granted HOLD_CYCLES+1 edges later (level 2), ack_b.
REQ-036 Level 3, b_up pulse -> level stays 3, ack_b and sat high same cycle; level 0, a_dn -> stays 0, sat.
REQ-037 a_up and a_dn edges same cycle -> no ack, level unchanged; a_up pulsed twice during HOLD -> only one further grant.
REQ-038 a_up held high through reset release -> no grant; rst_n low mid-HOLD with B pending -> level 0, no ack_b afterwards.
